// File: rtl/conv_pkg.sv
// Shared types and helpers for the single-MAC convolution sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        DRAIN,
        OUT,
        DONE
    } sched_state_t;

    function automatic int n_out(input int x_size, input int f_size);
        return x_size - f_size + 1;
    endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// Up-counter with sync clear, increment enable and terminal-count flag.
module conv_idx_counter #(
    parameter int W    = 8,
    parameter int LAST = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign last = (count == W'(LAST));

endmodule

// File: rtl/conv_mac_sched.sv
// Walks every valid output position of a single-MAC convolution and
// drives memory addresses, accumulator strobes and the output handshake.
module conv_mac_sched
    import conv_pkg::*;
#(
    parameter int X_SIZE   = 128,
    parameter int F_SIZE   = 32,
    parameter int X_ADDR_W = $clog2(X_SIZE),
    parameter int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [X_ADDR_W-1:0] x_addr,
    output logic [F_ADDR_W-1:0] f_addr,
    output logic                acc_clr,
    output logic                acc_en,
    output logic                m_valid_y,
    input  logic                m_ready_y,
    output logic                done,
    output logic                busy,
    output logic [X_ADDR_W-1:0] out_idx
);

    localparam int N_OUT = n_out(X_SIZE, F_SIZE);

    if (F_SIZE < 1 || F_SIZE > X_SIZE) begin : g_bad_size
        $error("conv_mac_sched: F_SIZE must be within 1..X_SIZE");
    end

    sched_state_t        state;
    logic [X_ADDR_W-1:0] k_cnt;
    logic [F_ADDR_W-1:0] j_cnt;
    logic                k_last;
    logic                j_last;
    logic                k_clr;
    logic                k_inc;
    logic                j_clr;
    logic                j_inc;

    assign k_clr = (state == DONE) || (state == IDLE && start);
    assign k_inc = (state == OUT) && m_ready_y && !k_last;
    assign j_clr = (state == DONE) || (state == OUT && m_ready_y);
    assign j_inc = (state == CLR || state == MAC) && !j_last;

    conv_idx_counter #(
        .W    (X_ADDR_W),
        .LAST (N_OUT - 1)
    ) u_k (
        .clk   (clk),
        .reset (reset),
        .clr   (k_clr),
        .inc   (k_inc),
        .count (k_cnt),
        .last  (k_last)
    );

    conv_idx_counter #(
        .W    (F_ADDR_W),
        .LAST (F_SIZE - 1)
    ) u_j (
        .clk   (clk),
        .reset (reset),
        .clr   (j_clr),
        .inc   (j_inc),
        .count (j_cnt),
        .last  (j_last)
    );

    // j holds at its last value through DRAIN/OUT, so addresses hold too.
    assign x_addr  = k_cnt + X_ADDR_W'(j_cnt);
    assign f_addr  = j_cnt;
    assign out_idx = k_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            m_valid_y <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            m_valid_y <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLR;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                CLR: begin
                    acc_en <= 1'b1;
                    state  <= j_last ? DRAIN : MAC;
                end
                MAC: begin
                    acc_en <= 1'b1;
                    if (j_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state     <= OUT;
                    m_valid_y <= 1'b1;
                end
                OUT: begin
                    if (!m_ready_y) begin
                        m_valid_y <= 1'b1;
                    end else if (k_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= CLR;
                        acc_clr <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_addr_range: assert property (@(posedge clk) disable iff (!reset)
        (int'(k_cnt) + int'(j_cnt) <= X_SIZE - 1));

    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset)
        !(acc_clr && acc_en));

endmodule
